icache_assoc: RTL

Parametrised N-way set-associative, read-only instruction cache with an integrated line-fill state machine, replacing the fixed 2-way, externally-filled instruction cache between the fetch stage and the memory arbiter. Lookup is single-cycle on a hit. A miss stalls fetch and fills the whole block from memory, one word per `mem_rvalid`. A true-LRU age field per way selects the victim, and a one-cycle flush invalidates the whole cache.

---
 rtl/icache_assoc.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative read-only instruction cache with an
// integrated line-fill FSM and true-LRU replacement.
// Optional build macro: ICACHE_PERF_EN adds saturating hit/miss counters;
// without it hit_cnt/miss_cnt are tied to zero.
module icache_assoc #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_valid,
    output logic              stall,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_W - 1 - OW - IW;
    localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AW = VW;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_nx;

    // Storage arrays
    logic [TW-1:0]     tag_mem  [WAYS][SETS];
    logic [DATA_W-1:0] data_mem [WAYS][SETS][WORDS];
    logic [SETS-1:0]   valid_mem[WAYS];
    logic [AW-1:0]     age_mem  [WAYS][SETS];

    // Fill context
    logic [TW-1:0] fill_tag;
    logic [IW-1:0] fill_idx;
    logic [OW-1:0] k;
    logic [VW-1:0] victim;
    logic          flush_pend;

    // Address split
    logic [OW-1:0] req_off;
    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic          unused_addr_bit;

    assign req_off         = cpu_addr[OW:1];
    assign req_idx         = cpu_addr[OW+IW:OW+1];
    assign req_tag         = cpu_addr[ADDR_W-1:OW+IW+1];
    assign unused_addr_bit = cpu_addr[0];

    logic              hit;
    logic [VW-1:0]     hit_way;
    logic [DATA_W-1:0] rd_word;
    logic [VW-1:0]     victim_nx;
    logic              inv_found;

    // Tag compare across all ways of the indexed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        rd_word = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_mem[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = VW'(w);
                rd_word = data_mem[w][req_idx][req_off];
            end
        end
    end

    // Victim choice: lowest invalid way, else the oldest way
    always_comb begin
        victim_nx = '0;
        inv_found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_mem[w][req_idx]) begin
                inv_found = 1'b1;
                victim_nx = VW'(w);
            end
        end
        if (!inv_found && (WAYS > 1)) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_mem[w][req_idx] == AW'(WAYS - 1))
                    victim_nx = VW'(w);
            end
        end
    end

    logic miss_start;
    logic last_word;
    logic do_flush;

    assign cpu_valid  = cpu_req && hit && (state == IDLE) && !flush;
    // Outputs read quiet while reset is held, even with cpu_req high
    assign stall      = rst_n && cpu_req && !cpu_valid;
    assign cpu_data   = rd_word;
    assign miss_start = (state == IDLE) && cpu_req && !hit && !flush;
    assign mem_req    = (state == FILL);
    assign mem_addr   = {fill_tag, fill_idx, k, 1'b0};
    assign last_word  = (state == FILL) && mem_rvalid && (k == OW'(WORDS - 1));
    // A flush seen during a fill lands on the completing edge, so the new line is dropped too
    assign do_flush   = ((state == IDLE) && flush) || (last_word && (flush || flush_pend));

    logic          upd_en;
    logic [VW-1:0] upd_way;
    logic [IW-1:0] upd_idx;
    logic [AW-1:0] upd_age;

    // Select which way/set gets promoted to MRU this cycle
    always_comb begin
        upd_en  = 1'b0;
        upd_way = '0;
        upd_idx = '0;
        if (cpu_valid) begin
            upd_en  = 1'b1;
            upd_way = hit_way;
            upd_idx = req_idx;
        end else if (last_word) begin
            upd_en  = 1'b1;
            upd_way = victim;
            upd_idx = fill_idx;
        end
        upd_age = age_mem[upd_way][upd_idx];
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (miss_start) state_nx = FILL;
            FILL: if (last_word)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Fill context: latched miss address, victim, word counter, deferred flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_tag   <= '0;
            fill_idx   <= '0;
            k          <= '0;
            victim     <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (miss_start) begin
                fill_tag <= req_tag;
                fill_idx <= req_idx;
                victim   <= victim_nx;
                k        <= '0;
            end else if ((state == FILL) && mem_rvalid) begin
                k <= k + 1'b1;
            end
            if (state == FILL)
                flush_pend <= (flush_pend || flush) && !last_word;
            else
                flush_pend <= 1'b0;
        end
    end

    // Valid bits and LRU ages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_mem[w] <= '0;
                for (int unsigned s = 0; s < SETS; s++)
                    age_mem[w][s] <= AW'(w);
            end
        end else if (do_flush) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_mem[w] <= '0;
                for (int unsigned s = 0; s < SETS; s++)
                    age_mem[w][s] <= AW'(w);
            end
        end else begin
            if (last_word)
                valid_mem[victim][fill_idx] <= 1'b1;
            if ((WAYS > 1) && upd_en) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (VW'(w) == upd_way)
                        age_mem[w][upd_idx] <= '0;
                    else if (age_mem[w][upd_idx] < upd_age)
                        age_mem[w][upd_idx] <= age_mem[w][upd_idx] + 1'b1;
                end
            end
        end
    end

    // Data and tag arrays: written by the fill, no reset needed
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_rvalid)
            data_mem[victim][fill_idx][k] <= mem_rdata;
        if (last_word)
            tag_mem[victim][fill_idx] <= fill_tag;
    end

`ifdef ICACHE_PERF_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (cpu_valid && (hit_q != '1))
                hit_q <= hit_q + 1'b1;
            if (miss_start && (miss_q != '1))
                miss_q <= miss_q + 1'b1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
